// File: rtl/cache_pkg.sv
// Shared data-cache definitions: block geometry, word size and the
// fill-controller state encoding.
package cache_pkg;

  // Geometry of one cache block.
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_W          = 16;
  localparam int WORD_BYTES      = WORD_W / 8;

  // Byte-offset bits inside a block: log2(2 * WORDS_PER_BLOCK).
  localparam int BLOCK_OFFSET_W  = $clog2(WORD_BYTES * WORDS_PER_BLOCK);

  // Word index inside a block, and the counter width that can hold
  // WORDS_PER_BLOCK itself (one extra bit).
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int FILL_CNT_W      = WORD_IDX_W + 1;

  // Fill controller states.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage : cache_pkg

// File: rtl/cache_fill_fsm.sv
// Data-cache miss handler. On a miss it stalls the pipeline, streams one
// block from pipelined main memory, writes each returned word into the
// data array, writes the tag with the last word and releases the stall.
//
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN: when defined the
// block is requested starting at the missed word and wrapping within the
// block; otherwise words are requested from word 0 upward. Cycle counts are
// the same in both modes.
//
// Handshake: there is no flow control on either side. memory_read is a
// one-cycle request that memory always accepts; memory_data_valid is a
// one-cycle response, one per request, in request order. miss_detected is a
// level held by the cache until fsm_busy falls.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [WORD_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [WORD_W-1:0] fill_data,
  output logic              write_tag_array,
  output logic              critical_word_valid,
  output fill_state_e       dbg_state
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = $clog2(2 * WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_e       state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  cw;
  logic [CNT_W-1:0]  ic;
  logic [CNT_W-1:0]  rc;
  // High for the first IDLE cycle after a fill: that cycle is the retried
  // lookup, so a still-asserted miss_detected must not start a new fill.
  logic              lookup_cycle;

  logic              issuing;
  logic              receiving;
  logic              last_word;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  recv_idx;

  // Bit 0 of the miss address is the byte within a word; never needed.
  logic              unused_miss_lsb;
  assign unused_miss_lsb = miss_address[0];

  assign dbg_state = state;

  // Word order inside the block for the issue and receive counters.
  always_comb begin
    issue_idx = '0;
    recv_idx  = '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    // Start at the missed word; IDX_W-bit addition wraps within the block.
    issue_idx = cw + ic[IDX_W-1:0];
    recv_idx  = cw + rc[IDX_W-1:0];
`else
    issue_idx = ic[IDX_W-1:0];
    recv_idx  = rc[IDX_W-1:0];
`endif
  end

  // Issue and receive sides run independently inside FILL.
  always_comb begin
    issuing   = (state == FILL) && (ic < CNT_FULL);
    receiving = (state == FILL) && memory_data_valid;
    last_word = receiving && (rc == CNT_LAST);
  end

  // Memory request and data-array write outputs; all zero when inactive.
  always_comb begin
    memory_read         = issuing;
    memory_address      = '0;
    write_data_array    = receiving;
    fill_address        = '0;
    fill_data           = '0;
    write_tag_array     = last_word;
    critical_word_valid = receiving && (recv_idx == cw);
    if (issuing) begin
      memory_address = base | (ADDR_W'(issue_idx) << 1);
    end
    if (receiving) begin
      fill_address = base | (ADDR_W'(recv_idx) << 1);
      fill_data    = memory_data;
    end
  end

  // Fill FSM: block base, critical word, both counters and the stall flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base         <= '0;
      cw           <= '0;
      ic           <= '0;
      rc           <= '0;
      lookup_cycle <= 1'b0;
      fsm_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lookup_cycle <= 1'b0;
          if (miss_detected && !lookup_cycle) begin
            base     <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cw       <= miss_address[OFF_W-1:1];
            ic       <= '0;
            rc       <= '0;
            state    <= FILL;
            fsm_busy <= 1'b1;
          end
        end
        FILL: begin
          if (issuing) begin
            ic <= ic + 1'b1;
          end
          if (receiving) begin
            rc <= rc + 1'b1;
          end
          if (last_word) begin
            state        <= IDLE;
            fsm_busy     <= 1'b0;
            lookup_cycle <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          fsm_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              miss_detected;
  logic [15:0]       miss_address;
  logic [15:0]       memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              memory_read;
  logic [15:0]       memory_address;
  logic              write_data_array;
  logic [15:0]       fill_address;
  logic [15:0]       fill_data;
  logic              write_tag_array;
  logic              critical_word_valid;
  fill_state_e       dbg_state;

  int n_cmp;
  int n_bad;
  logic spur;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .miss_detected       (miss_detected),
    .miss_address        (miss_address),
    .memory_data         (memory_data),
    .memory_data_valid   (memory_data_valid),
    .fsm_busy            (fsm_busy),
    .memory_read         (memory_read),
    .memory_address      (memory_address),
    .write_data_array    (write_data_array),
    .fill_address        (fill_address),
    .fill_data           (fill_data),
    .write_tag_array     (write_tag_array),
    .critical_word_valid (critical_word_valid),
    .dbg_state           (dbg_state)
  );

  // Main memory: read at edge Ek returns data in the cycle after E(k+3).
  logic        pv0, pv1, pv2, pv3;
  logic [15:0] pa0, pa1, pa2, pa3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv0 <= 1'b0; pv1 <= 1'b0; pv2 <= 1'b0; pv3 <= 1'b0;
      pa0 <= '0;   pa1 <= '0;   pa2 <= '0;   pa3 <= '0;
    end else begin
      pv0 <= memory_read; pa0 <= memory_address;
      pv1 <= pv0;         pa1 <= pa0;
      pv2 <= pv1;         pa2 <= pa1;
      pv3 <= pv2;         pa3 <= pa2;
    end
  end
  assign memory_data       = pv3 ? (pa3 ^ 16'h5A5A) : 16'h0000;
  assign memory_data_valid = pv3 | spur;

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(fsm_busy), 0);
    chk({tag, ".read"}, 32'(memory_read), 0);
    chk({tag, ".maddr"}, 32'(memory_address), 0);
    chk({tag, ".wr"}, 32'(write_data_array), 0);
    chk({tag, ".faddr"}, 32'(fill_address), 0);
    chk({tag, ".fdata"}, 32'(fill_data), 0);
    chk({tag, ".tag"}, 32'(write_tag_array), 0);
    chk({tag, ".crit"}, 32'(critical_word_valid), 0);
  endtask

  // Drive one miss (called at a negedge in IDLE) and check cycles 1..14.
  // base and cw are hand-derived from the miss address by the caller.
  task automatic run_fill(input string tag, input logic [15:0] addr,
                          input logic [15:0] base, input int cw, input bit disturb);
    int start;
    int crit_cycle;
    int wr_cnt;
    int tag_cnt;
    logic [15:0] ea;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start = cw;
    crit_cycle = 5;
`else
    start = 0;
    crit_cycle = 5 + cw;
`endif
    wr_cnt = 0;
    tag_cnt = 0;
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk({tag, ".busy"}, 32'(fsm_busy), (c <= 12) ? 1 : 0);
      chk({tag, ".read"}, 32'(memory_read), (c <= 8) ? 1 : 0);
      ea = (c <= 8) ? base + 16'(2 * ((start + c - 1) % 8)) : 16'h0000;
      chk({tag, ".maddr"}, 32'(memory_address), 32'(ea));
      chk({tag, ".wr"}, 32'(write_data_array), (c >= 5 && c <= 12) ? 1 : 0);
      ea = (c >= 5 && c <= 12) ? base + 16'(2 * ((start + c - 5) % 8)) : 16'h0000;
      chk({tag, ".faddr"}, 32'(fill_address), 32'(ea));
      chk({tag, ".fdata"}, 32'(fill_data), (c >= 5 && c <= 12) ? 32'(ea ^ 16'h5A5A) : 0);
      chk({tag, ".crit"}, 32'(critical_word_valid), (c == crit_cycle) ? 1 : 0);
      chk({tag, ".tag"}, 32'(write_tag_array), (c == 12) ? 1 : 0);
      if (write_data_array) wr_cnt++;
      if (write_tag_array) tag_cnt++;
      if (disturb && c == 3) miss_address = 16'h4000;
      // miss stays high in cycle 13 (lookup cycle) and drops in cycle 14
      if (c == 14) miss_detected = 1'b0;
    end
    chk({tag, ".n_writes"}, 32'(wr_cnt), 8);
    chk({tag, ".n_tags"}, 32'(tag_cnt), 1);
  endtask

  initial begin
    int tag_cnt;
    int wr_cnt;
    n_cmp = 0;
    n_bad = 0;
    spur  = 1'b0;
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // basic miss, then a top-of-memory block
    run_fill("m1236", 16'h1236, 16'h1230, 3, 1'b0);
    run_fill("mfffe", 16'hFFFE, 16'hFFF0, 7, 1'b0);

    // second miss address during FILL is ignored
    run_fill("dist", 16'h1236, 16'h1230, 3, 1'b1);

    // reset at cycle 7 of a fill
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    for (int c = 1; c <= 7; c++) @(negedge clk);
    chk("rst7.busy_before", 32'(fsm_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst7");
    @(negedge clk);
    miss_detected = 1'b0;
    rst_n = 1'b1;
    tag_cnt = 0;
    wr_cnt  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write_tag_array) tag_cnt++;
      if (write_data_array) wr_cnt++;
    end
    chk("rst7.no_tag", 32'(tag_cnt), 0);
    chk("rst7.no_wr", 32'(wr_cnt), 0);
    run_fill("m2468", 16'h2468, 16'h2460, 4, 1'b0);

    // spurious memory_data_valid in IDLE
    spur = 1'b1;
    #1;
    chk("spur.wr", 32'(write_data_array), 0);
    chk("spur.tag", 32'(write_tag_array), 0);
    chk("spur.crit", 32'(critical_word_valid), 0);
    @(negedge clk);
    spur = 1'b0;
    chk("spur.busy", 32'(fsm_busy), 0);
    run_fill("post_spur", 16'h1236, 16'h1230, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cache_fill_fsm
